i_memory: RTL and testbench

I_MEMORY -- requirements
Module: i_memory

---
 rtl/i_memory_if.sv | 42 ++++
 rtl/i_memory.sv | 96 +++++++++
 tb/tb_i_memory.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/i_memory_if.sv
// EX/MEM stage bus: execute-side inputs plus stall/flush, and the registered
// controls, branch select, load data and fault flag returned by the memory stage.
interface i_memory_if #(
    parameter int WORD = 64
);
    logic            stall;
    logic            flush;
    logic [WORD-1:0] Branch_target;
    logic [WORD-1:0] ALUresult;
    logic            zero;
    logic [WORD-1:0] Read_data2;
    logic            Branch;
    logic            Uncond_branch;
    logic            MemRead;
    logic            MemWrite;
    logic            MemtoReg;
    logic            RegWrite;
    logic [4:0]      Write_reg;

    logic            PCSrc;
    logic [WORD-1:0] Branch_target_out;
    logic [WORD-1:0] Read_data;
    logic [WORD-1:0] ALUresult_out;
    logic            MemtoReg_out;
    logic            RegWrite_out;
    logic [4:0]      Write_reg_out;
    logic            mem_fault;

    modport master (
        output stall, flush, Branch_target, ALUresult, zero, Read_data2,
               Branch, Uncond_branch, MemRead, MemWrite, MemtoReg, RegWrite, Write_reg,
        input  PCSrc, Branch_target_out, Read_data, ALUresult_out,
               MemtoReg_out, RegWrite_out, Write_reg_out, mem_fault
    );

    modport slave (
        input  stall, flush, Branch_target, ALUresult, zero, Read_data2,
               Branch, Uncond_branch, MemRead, MemWrite, MemtoReg, RegWrite, Write_reg,
        output PCSrc, Branch_target_out, Read_data, ALUresult_out,
               MemtoReg_out, RegWrite_out, Write_reg_out, mem_fault
    );
endinterface

// File: rtl/i_memory.sv
// Memory stage of a 64-bit pipeline: EX/MEM register, doubleword data memory,
// branch select and a sticky fault flag for misaligned or out-of-range accesses.
module i_memory #(
    parameter int WORD      = 64,
    parameter int MEM_DEPTH = 128
) (
    input  logic      clk,
    input  logic      reset,
    i_memory_if.slave bus
);
    localparam int              IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [WORD-1:0] MEM_BYTES = WORD'(64'(MEM_DEPTH) << 3);

    logic [WORD-1:0]  r_branchTarget;
    logic [WORD-1:0]  r_aluResult;
    logic             r_zero;
    logic [WORD-1:0]  r_readData2;
    logic             r_branch;
    logic             r_uncondBranch;
    logic             r_memRead;
    logic             r_memWrite;
    logic             r_memtoReg;
    logic             r_regWrite;
    logic [4:0]       r_writeReg;
    logic             r_memFault;
    logic [WORD-1:0]  r_mem [MEM_DEPTH];

    logic [IDX_W-1:0] w_index;
    logic             w_aligned;
    logic             w_inRange;
    logic             w_accessOk;
    logic             w_badAccess;

    // A flushed bubble still loads the data fields; only the controls matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branchTarget <= '0;
            r_aluResult    <= '0;
            r_zero         <= 1'b0;
            r_readData2    <= '0;
            r_branch       <= 1'b0;
            r_uncondBranch <= 1'b0;
            r_memRead      <= 1'b0;
            r_memWrite     <= 1'b0;
            r_memtoReg     <= 1'b0;
            r_regWrite     <= 1'b0;
            r_writeReg     <= '0;
        end else if (bus.flush || !bus.stall) begin
            r_branchTarget <= bus.Branch_target;
            r_aluResult    <= bus.ALUresult;
            r_zero         <= bus.zero;
            r_readData2    <= bus.Read_data2;
            r_writeReg     <= bus.Write_reg;
            r_branch       <= bus.Branch        & ~bus.flush;
            r_uncondBranch <= bus.Uncond_branch & ~bus.flush;
            r_memRead      <= bus.MemRead       & ~bus.flush;
            r_memWrite     <= bus.MemWrite      & ~bus.flush;
            r_memtoReg     <= bus.MemtoReg      & ~bus.flush;
            r_regWrite     <= bus.RegWrite      & ~bus.flush;
        end
    end

    // Full-width compare so huge addresses never alias back into the array.
    assign w_index     = r_aluResult[IDX_W+2:3];
    assign w_aligned   = (r_aluResult[2:0] == 3'b000);
    assign w_inRange   = (r_aluResult < MEM_BYTES);
    assign w_accessOk  = w_aligned & w_inRange;
    assign w_badAccess = (r_memRead | r_memWrite) & ~w_accessOk;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_memWrite && w_accessOk) begin
            r_mem[w_index] <= r_readData2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memFault <= 1'b0;
        end else if (w_badAccess) begin
            r_memFault <= 1'b1;
        end
    end

    assign bus.PCSrc             = (r_branch & r_zero) | r_uncondBranch;
    assign bus.Branch_target_out = r_branchTarget;
    assign bus.ALUresult_out     = r_aluResult;
    assign bus.MemtoReg_out      = r_memtoReg;
    assign bus.RegWrite_out      = r_regWrite;
    assign bus.Write_reg_out     = r_writeReg;
    assign bus.mem_fault         = r_memFault;
    assign bus.Read_data         = (r_memRead && w_accessOk) ? r_mem[w_index] : '0;
endmodule

// File: tb/tb_i_memory.sv
// Randomized scoreboard bench for i_memory: a behavioural model predicts each
// post-edge output set, and a monitor compares after every rising edge.
module tb_i_memory;
    typedef struct packed {
        logic [63:0] target;
        logic [63:0] alu;
        logic [63:0] rd2;
        logic        zero;
        logic        br;
        logic        ub;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic [4:0]  wr;
    } instr_t;

    typedef struct packed {
        logic        dataKnown;
        logic        pcSrc;
        logic [63:0] target;
        logic [63:0] alu;
        logic        m2r;
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] readData;
        logic        fault;
    } expect_t;

    logic clk = 1'b0;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;

    i_memory_if #(.WORD(64)) busIf();

    i_memory #(.WORD(64), .MEM_DEPTH(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    expect_t     expQ[$];
    instr_t      mInstr;
    logic        mDataKnown;
    logic        mFault;
    logic [63:0] mMem [128];

    function automatic logic addrOk(input logic [63:0] a);
        return (a % 64'd8 == 64'd0) && (a < 64'd1024);
    endfunction

    function automatic instr_t mk(input logic [63:0] alu, input logic [63:0] rd2,
                                  input logic mr, input logic mw);
        instr_t x;
        x     = '0;
        x.alu = alu;
        x.rd2 = rd2;
        x.mr  = mr;
        x.mw  = mw;
        x.m2r = mr;
        x.rw  = mr;
        x.wr  = 5'd3;
        return x;
    endfunction

    function automatic instr_t randInstr();
        instr_t x;
        int     sel;
        sel = $urandom_range(0, 11);
        if (sel <= 8)       x.alu = 64'($urandom_range(0, 15)) * 64'd8;
        else if (sel == 9)  x.alu = 64'($urandom_range(0, 127)) * 64'd8 + 64'($urandom_range(1, 7));
        else if (sel == 10) x.alu = 64'd1024 + 64'($urandom_range(0, 7)) * 64'd8;
        else                x.alu = 64'hFFFF_FFFF_FFFF_FFF8;
        x.target = {$urandom, $urandom};
        x.rd2    = {$urandom, $urandom};
        x.zero   = 1'($urandom_range(0, 1));
        x.br     = 1'($urandom_range(0, 1));
        x.ub     = ($urandom_range(0, 3) == 0);
        x.mr     = 1'($urandom_range(0, 1));
        x.mw     = ($urandom_range(0, 2) == 0);
        x.m2r    = 1'($urandom_range(0, 1));
        x.rw     = 1'($urandom_range(0, 1));
        x.wr     = 5'($urandom_range(0, 31));
        return x;
    endfunction

    // Drive one cycle of inputs, advance the model by one edge and queue the prediction.
    task automatic applyStimulus(input logic rst, input logic st, input logic fl, input instr_t ins);
        expect_t e;
        @(negedge clk);
        reset               = rst;
        busIf.stall         = st;
        busIf.flush         = fl;
        busIf.Branch_target = ins.target;
        busIf.ALUresult     = ins.alu;
        busIf.zero          = ins.zero;
        busIf.Read_data2    = ins.rd2;
        busIf.Branch        = ins.br;
        busIf.Uncond_branch = ins.ub;
        busIf.MemRead       = ins.mr;
        busIf.MemWrite      = ins.mw;
        busIf.MemtoReg      = ins.m2r;
        busIf.RegWrite      = ins.rw;
        busIf.Write_reg     = ins.wr;

        if (rst) begin
            mInstr     = '0;
            mDataKnown = 1'b1;
            mFault     = 1'b0;
            for (int i = 0; i < 128; i++) mMem[i] = '0;
        end else begin
            if (mInstr.mw && addrOk(mInstr.alu)) mMem[int'(mInstr.alu / 64'd8)] = mInstr.rd2;
            if ((mInstr.mr || mInstr.mw) && !addrOk(mInstr.alu)) mFault = 1'b1;
            if (fl) begin
                mInstr.br  = 1'b0;
                mInstr.ub  = 1'b0;
                mInstr.mr  = 1'b0;
                mInstr.mw  = 1'b0;
                mInstr.m2r = 1'b0;
                mInstr.rw  = 1'b0;
                mDataKnown = 1'b0;
            end else if (!st) begin
                mInstr     = ins;
                mDataKnown = 1'b1;
            end
        end

        e.dataKnown = mDataKnown;
        e.pcSrc     = (mInstr.br && mInstr.zero) || mInstr.ub;
        e.target    = mInstr.target;
        e.alu       = mInstr.alu;
        e.m2r       = mInstr.m2r;
        e.rw        = mInstr.rw;
        e.wr        = mInstr.wr;
        e.fault     = mFault;
        e.readData  = (mInstr.mr && addrOk(mInstr.alu)) ? mMem[int'(mInstr.alu / 64'd8)] : 64'd0;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every edge that has a queued prediction gets its outputs compared.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("PCSrc",        64'(busIf.PCSrc),        64'(e.pcSrc));
                checkOutput("MemtoReg_out", 64'(busIf.MemtoReg_out), 64'(e.m2r));
                checkOutput("RegWrite_out", 64'(busIf.RegWrite_out), 64'(e.rw));
                checkOutput("Read_data",    busIf.Read_data,         e.readData);
                checkOutput("mem_fault",    64'(busIf.mem_fault),    64'(e.fault));
                if (e.dataKnown) begin
                    checkOutput("Branch_target_out", busIf.Branch_target_out, e.target);
                    checkOutput("ALUresult_out",     busIf.ALUresult_out,     e.alu);
                    checkOutput("Write_reg_out",     64'(busIf.Write_reg_out), 64'(e.wr));
                end
            end
        end
    end

    initial begin
        instr_t x;
        int     drain;
        reset = 1'b1;
        busIf.stall = 1'b0;
        busIf.flush = 1'b0;
        mInstr = '0;
        mDataKnown = 1'b1;
        mFault = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, mk(64'd8, 64'd99, 1'b0, 1'b1));

        // Store then load of the same address, then a clean idle cycle.
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd520, 64'd10, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd520, 64'd0, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        // Branch selection cases.
        x = '0; x.br = 1'b1; x.zero = 1'b1; x.target = 64'h0000_0000_0000_4000;
        applyStimulus(1'b0, 1'b0, 1'b0, x);
        x.zero = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, x);
        x.br = 1'b0; x.ub = 1'b1; x.target = 64'h0000_0000_0000_8000;
        applyStimulus(1'b0, 1'b0, 1'b0, x);

        // Stall holds the uncond branch for 3 cycles, then stall+flush bubbles it.
        x = mk(64'd16, 64'd5, 1'b1, 1'b0);
        x.rw = 1'b1; x.ub = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, x);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, randInstr());
        applyStimulus(1'b0, 1'b1, 1'b1, randInstr());

        // Faults: misaligned load, out-of-range store, top-of-space address, then good accesses.
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd521, 64'd0, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd1024, 64'd77, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd0, 64'd0, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd520, 64'd0, 1'b1, 1'b0));

        // Reset on the same edge as a store, then load the same address.
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd8, 64'd15, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 1'b0, mk(64'd8, 64'd15, 1'b0, 1'b1));
        applyStimulus(1'b0, 1'b0, 1'b0, mk(64'd8, 64'd0, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0),
                          randInstr());
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        testsRun++;
        if (expQ.size() > 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d predictions left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
